// File: rtl/dma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_arb_pkg
// Brief    : Shared state encoding, descriptor width and size predicate for
//            the DMA channel arbiter.
// Revision : 1.0
// ============================================================================
package dma_arb_pkg;

    localparam int STATE_W = 8;
    localparam int DESC_W  = 32;

    localparam logic [STATE_W-1:0] IDLE  = 8'h00;
    localparam logic [STATE_W-1:0] ISSUE = 8'h01;
    localparam logic [STATE_W-1:0] WAIT  = 8'h02;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = IDLE,
        ST_ISSUE = ISSUE,
        ST_WAIT  = WAIT
    } state_t;

    // The splitter never terminates on a zero or sign-bit byte count.
    function automatic logic size_invalid(input logic [DESC_W-1:0] size);
        return (size == '0) || size[DESC_W-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : dma_rr_pick
// Brief    : Combinational round-robin selector starting after last_grant.
// Revision : 1.0
// ============================================================================
module dma_rr_pick #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        cidx = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (int'(last_grant) + i) % NUM_CH;
            cidx = IDX_W'(cand);
            if (!any && req[cidx]) begin
                any       = 1'b1;
                idx       = cidx;
                gnt[cidx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_channel_arbiter
// Brief    : Round-robin sharing of one transmission splitter between NUM_CH
//            DMA requesters. Optional watchdog: DMA_ARB_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int TIMEOUT_CYCLES = 65535,
    localparam int IDX_W          = $clog2(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DESC_W-1:0] ch_host_addr,
    input  logic [NUM_CH*DESC_W-1:0] ch_dev_addr,
    input  logic [NUM_CH*DESC_W-1:0] ch_size,
    input  logic [NUM_CH-1:0]        ch_dir_write,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DESC_W-1:0]        conf_start_address_host,
    output logic [DESC_W-1:0]        conf_start_address_device,
    output logic [DESC_W-1:0]        conf_size,
    output logic                     conf_dir_write,
    output logic                     conf_valid,
    input  logic                     conf_transaction_done,
    output logic                     splitter_abort,
    output logic                     busy,
    output logic [IDX_W-1:0]         active_ch
);

    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("dma_channel_arbiter: NUM_CH must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [DESC_W-1:0] w_host [NUM_CH];
    logic [DESC_W-1:0] w_dev  [NUM_CH];
    logic [DESC_W-1:0] w_size [NUM_CH];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_unpack
        assign w_host[n] = ch_host_addr[DESC_W*n +: DESC_W];
        assign w_dev[n]  = ch_dev_addr[DESC_W*n +: DESC_W];
        assign w_size[n] = ch_size[DESC_W*n +: DESC_W];
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_last_grant;
    logic [NUM_CH-1:0] w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic [NUM_CH-1:0] w_ack;
    logic [NUM_CH-1:0] w_done;
    logic [NUM_CH-1:0] w_err;
    logic              w_valid;
    logic              w_latch;
    logic [NUM_CH-1:0] w_act_oh;

    dma_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req        (ch_req),
        .last_grant (r_last_grant),
        .gnt        (w_gnt),
        .idx        (w_idx),
        .any        (w_any)
    );

    assign w_act_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << active_ch;

`ifdef DMA_ARB_WATCHDOG_EN
    logic [31:0] r_wd_cnt;
    logic        w_wd_clr;
    logic        w_abort;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = '0;
        w_done      = '0;
        w_err       = '0;
        w_valid     = 1'b0;
        w_latch     = 1'b0;
`ifdef DMA_ARB_WATCHDOG_EN
        w_wd_clr    = 1'b0;
        w_abort     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_latch = 1'b1;
                    w_ack   = w_gnt;
                    if (size_invalid(w_size[w_idx])) begin
                        w_done = w_gnt;
                        w_err  = w_gnt;
                    end else begin
                        w_valid     = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
`ifdef DMA_ARB_WATCHDOG_EN
                w_wd_clr    = 1'b1;
`endif
            end
            ST_WAIT: begin
                // A done coinciding with the timeout wins: it is a success.
                if (conf_transaction_done) begin
                    w_done      = w_act_oh;
                    w_state_nxt = ST_IDLE;
                end
`ifdef DMA_ARB_WATCHDOG_EN
                else if (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    w_done      = w_act_oh;
                    w_err       = w_act_oh;
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state                   <= ST_IDLE;
            r_last_grant              <= IDX_W'(NUM_CH - 1);
            ch_ack                    <= '0;
            ch_done                   <= '0;
            ch_err                    <= '0;
            conf_valid                <= 1'b0;
            busy                      <= 1'b0;
            active_ch                 <= '0;
            conf_start_address_host   <= '0;
            conf_start_address_device <= '0;
            conf_size                 <= '0;
            conf_dir_write            <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            ch_ack     <= w_ack;
            ch_done    <= w_done;
            ch_err     <= w_err;
            conf_valid <= w_valid;
            busy       <= (w_state_nxt != ST_IDLE);
            if (w_latch) begin
                r_last_grant              <= w_idx;
                active_ch                 <= w_idx;
                conf_start_address_host   <= w_host[w_idx];
                conf_start_address_device <= w_dev[w_idx];
                conf_size                 <= w_size[w_idx];
                conf_dir_write            <= ch_dir_write[w_idx];
            end
        end
    end

`ifdef DMA_ARB_WATCHDOG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd_cnt       <= '0;
            splitter_abort <= 1'b0;
        end else begin
            splitter_abort <= w_abort;
            if (w_wd_clr) begin
                r_wd_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
        end
    end
`else
    assign splitter_abort = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_channel_arbiter
// Brief    : Directed table-driven bench for dma_channel_arbiter.
// Revision : 1.0
// ============================================================================
module tb_dma_channel_arbiter;

    localparam int NUM_CH = 4;
    localparam int TO     = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ch_req;
    logic [127:0]  ch_host_addr;
    logic [127:0]  ch_dev_addr;
    logic [127:0]  ch_size;
    logic [3:0]    ch_dir_write;
    logic [3:0]    ch_ack;
    logic [3:0]    ch_done;
    logic [3:0]    ch_err;
    logic [31:0]   conf_host;
    logic [31:0]   conf_dev;
    logic [31:0]   conf_size;
    logic          conf_dir;
    logic          conf_valid;
    logic          done_in;
    logic          abort;
    logic          busy;
    logic [1:0]    active_ch;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dma_channel_arbiter #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .ch_req                    (ch_req),
        .ch_host_addr              (ch_host_addr),
        .ch_dev_addr               (ch_dev_addr),
        .ch_size                   (ch_size),
        .ch_dir_write              (ch_dir_write),
        .ch_ack                    (ch_ack),
        .ch_done                   (ch_done),
        .ch_err                    (ch_err),
        .conf_start_address_host   (conf_host),
        .conf_start_address_device (conf_dev),
        .conf_size                 (conf_size),
        .conf_dir_write            (conf_dir),
        .conf_valid                (conf_valid),
        .conf_transaction_done     (done_in),
        .splitter_abort            (abort),
        .busy                      (busy),
        .active_ch                 (active_ch)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the ISSUE cycle; drives the transfer to completion.
    task automatic finish_xfer(input logic [3:0] exp_ch);
        tick();
        chk("issue_valid_drop", 32'(conf_valid), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("xfer_done", 32'(ch_done), 32'(exp_ch));
        chk("xfer_err", 32'(ch_err), 32'd0);
        chk("xfer_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0]   req;
        logic [127:0] sizes;
        logic [3:0]   exp_ack;
        logic [3:0]   exp_err;
        logic         exp_valid;
        logic         exp_dir;
        logic [31:0]  exp_size;
        logic [31:0]  exp_host;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog_timer
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] exp_rr;
        vecs[0] = '{4'b0010, {32'd0, 32'd0, 32'd300, 32'd0}, 4'b0010, 4'b0000, 1'b1, 1'b1, 32'd300, 32'h1000};
        vecs[1] = '{4'b0100, {32'd0, 32'd0, 32'd0, 32'd0}, 4'b0100, 4'b0100, 1'b0, 1'b0, 32'd0, 32'h0};
        vecs[2] = '{4'b0100, {32'd0, 32'h8000_0000, 32'd0, 32'd0}, 4'b0100, 4'b0100, 1'b0, 1'b0, 32'd0, 32'h0};
        vecs[3] = '{4'b1111, {32'd40, 32'd30, 32'd20, 32'd10}, 4'b1000, 4'b0000, 1'b1, 1'b0, 32'd40, 32'h1200};
        vecs[4] = '{4'b1111, {32'd40, 32'd30, 32'd20, 32'd10}, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'd10, 32'h0F00};
        vecs[5] = '{4'b1010, {32'd40, 32'd30, 32'd20, 32'd10}, 4'b0010, 4'b0000, 1'b1, 1'b1, 32'd20, 32'h1000};
        vecs[6] = '{4'b1001, {32'hFFFF_FFFF, 32'd0, 32'd0, 32'h7FFF_FFFF}, 4'b1000, 4'b1000, 1'b0, 1'b0, 32'd0, 32'h0};
        vecs[7] = '{4'b1001, {32'hFFFF_FFFF, 32'd0, 32'd0, 32'h7FFF_FFFF}, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0F00};
        vecs[8] = '{4'b0001, {32'd0, 32'd0, 32'd0, 32'd1}, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'd1, 32'h0F00};

        rst          = 1'b1;
        ch_req       = '0;
        ch_size      = '0;
        done_in      = 1'b0;
        ch_host_addr = {32'h1200, 32'h1100, 32'h1000, 32'h0F00};
        ch_dev_addr  = {32'h2200, 32'h2100, 32'h2000, 32'h1F00};
        ch_dir_write = 4'b0010;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ack", 32'(ch_ack), 32'd0);
        chk("rst_done", 32'(ch_done | ch_err), 32'd0);
        chk("rst_valid", 32'(conf_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_conf_size", conf_size, 32'd0);
        chk("rst_conf_host", conf_host, 32'd0);

        for (int v = 0; v < 9; v++) begin
            ch_size = vecs[v].sizes;
            ch_req  = vecs[v].req;
            tick();
            ch_req = '0;
            chk($sformatf("v%0d_ack", v), 32'(ch_ack), 32'(vecs[v].exp_ack));
            chk($sformatf("v%0d_done", v), 32'(ch_done),
                vecs[v].exp_valid ? 32'd0 : 32'(vecs[v].exp_ack));
            chk($sformatf("v%0d_err", v), 32'(ch_err), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_valid", v), 32'(conf_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk($sformatf("v%0d_size", v), conf_size, vecs[v].exp_size);
                chk($sformatf("v%0d_host", v), conf_host, vecs[v].exp_host);
                chk($sformatf("v%0d_dev", v), conf_dev, vecs[v].exp_host + 32'h1000);
                chk($sformatf("v%0d_dir", v), 32'(conf_dir), 32'(vecs[v].exp_dir));
                finish_xfer(vecs[v].exp_ack);
            end
        end

        // Round-robin from reset with all channels requesting continuously.
        rst     = 1'b1;
        ch_size = {32'd40, 32'd30, 32'd20, 32'd10};
        ch_req  = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_rr = 4'b0001 << (i % 4);
            chk($sformatf("rr%0d_ack", i), 32'(ch_ack), 32'(exp_rr));
            chk($sformatf("rr%0d_valid", i), 32'(conf_valid), 32'd1);
            tick();
            done_in = 1'b1;
            tick();
            done_in = 1'b0;
            chk($sformatf("rr%0d_done", i), 32'(ch_done), 32'(exp_rr));
            if (i == 4) ch_req = '0;
            tick();
        end
        chk("rr_stop_ack", 32'(ch_ack), 32'd0);

        // Reset in the middle of WAIT, then a ch3-only request.
        ch_req = 4'b0001;
        tick();
        ch_req = '0;
        chk("mr_ack", 32'(ch_ack), 32'b0001);
        tick();
        chk("mr_busy_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_valid", 32'(conf_valid), 32'd0);
        chk("mr_ch", 32'(ch_ack | ch_done | ch_err), 32'd0);
        chk("mr_conf_size", conf_size, 32'd0);
        ch_req = 4'b1000;
        tick();
        ch_req = '0;
        chk("mr3_ack", 32'(ch_ack), 32'b1000);
        chk("mr3_active", 32'(active_ch), 32'd3);
        chk("mr3_size", conf_size, 32'd40);
        finish_xfer(4'b1000);

        // Spurious done in IDLE and in ISSUE.
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("sp_idle_done", 32'(ch_done), 32'd0);
        chk("sp_idle_busy", 32'(busy), 32'd0);
        ch_req = 4'b0010;
        tick();
        ch_req  = '0;
        done_in = 1'b1;
        chk("sp_issue_ack", 32'(ch_ack), 32'b0010);
        tick();
        done_in = 1'b0;
        chk("sp_issue_done", 32'(ch_done), 32'd0);
        chk("sp_issue_busy", 32'(busy), 32'd1);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("sp_final_done", 32'(ch_done), 32'b0010);

        // Splitter never completes.
        ch_req = 4'b0100;
        tick();
        ch_req = '0;
        chk("wd_ack", 32'(ch_ack), 32'b0100);
        tick();
        repeat (TO - 1) tick();
        chk("wd_pre_abort", 32'(abort), 32'd0);
        chk("wd_pre_done", 32'(ch_done), 32'd0);
        tick();
`ifdef DMA_ARB_WATCHDOG_EN
        chk("wd_abort", 32'(abort), 32'd1);
        chk("wd_done", 32'(ch_done), 32'b0100);
        chk("wd_err", 32'(ch_err), 32'b0100);
        chk("wd_busy", 32'(busy), 32'd0);
        tick();
        chk("wd_abort_pulse", 32'(abort), 32'd0);
`else
        chk("nowd_abort", 32'(abort), 32'd0);
        chk("nowd_done", 32'(ch_done), 32'd0);
        chk("nowd_busy", 32'(busy), 32'd1);
        repeat (30) tick();
        chk("nowd_busy_late", 32'(busy), 32'd1);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("nowd_done_late", 32'(ch_done), 32'b0100);
        chk("nowd_err_late", 32'(ch_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
